// File: rtl/skinny_round_ctrl.sv
// Skinny-128 round controller: sequences NUM_ROUNDS rounds of ROUND_CYCLES cycles per block
// and drives the 6-bit LFSR round constant into the AddConstants stage.
module skinny_round_ctrl #(
  parameter int NUM_ROUNDS   = 56,
  parameter int ROUND_CYCLES = 1,
  parameter int RW           = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          load,
  output logic          round_en,
  output logic [5:0]    roundcst,
  output logic [RW-1:0] round_idx,
  output logic          first_round,
  output logic          last_round,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int            CW       = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(ROUND_CYCLES - 1);
  localparam logic [RW-1:0] IDX_LAST = RW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state, state_next;
  logic [5:0]    rc, rc_next;
  logic [RW-1:0] idx, idx_next;
  logic [CW-1:0] cyc, cyc_next;
  logic          round_end;

  assign round_end = (state == RUN) && (cyc == CYC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rc    <= 6'h00;
      idx   <= '0;
      cyc   <= '0;
    end else begin
      state <= state_next;
      rc    <= rc_next;
      idx   <= idx_next;
      cyc   <= cyc_next;
    end
  end

  // abort overrides everything, including an accept in IDLE
  always_comb begin
    state_next = state;
    rc_next    = rc;
    idx_next   = idx;
    cyc_next   = cyc;
    if (abort) begin
      state_next = IDLE;
      rc_next    = 6'h00;
      idx_next   = '0;
      cyc_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_next = RUN;
            rc_next    = 6'h01;
            idx_next   = '0;
            cyc_next   = '0;
          end
        end
        RUN: begin
          if (round_end) begin
            if (idx == IDX_LAST) begin
              state_next = DONE;
            end else begin
              idx_next = idx + RW'(1);
              cyc_next = '0;
              rc_next  = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            end
          end else begin
            cyc_next = cyc + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign load        = in_ready & in_valid & ~abort;
  assign round_en    = round_end;
  assign roundcst    = rc;
  assign round_idx   = idx;
  assign first_round = (state == RUN) && (idx == '0);
  assign last_round  = (state == RUN) && (idx == IDX_LAST);
  assign out_valid   = (state == DONE);

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Bench for skinny_round_ctrl: two configurations (56x1 and 4x3) driven by shared inputs,
// checked every cycle against a cycle-count model plus directed literal expectations.
module tb_skinny_round_ctrl;

  localparam int NR_A = 56;
  localparam int RC_A = 1;
  localparam int RW_A = 6;
  localparam int NR_B = 4;
  localparam int RC_B = 3;
  localparam int RW_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic            a_in_ready, a_load, a_round_en, a_first, a_last, a_out_valid;
  logic [5:0]      a_roundcst;
  logic [RW_A-1:0] a_round_idx;
  logic            b_in_ready, b_load, b_round_en, b_first, b_last, b_out_valid;
  logic [5:0]      b_roundcst;
  logic [RW_B-1:0] b_round_idx;

  always #5 clk = ~clk;

  skinny_round_ctrl #(.NUM_ROUNDS(NR_A), .ROUND_CYCLES(RC_A), .RW(RW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(a_in_ready),
    .load(a_load), .round_en(a_round_en), .roundcst(a_roundcst), .round_idx(a_round_idx),
    .first_round(a_first), .last_round(a_last), .out_valid(a_out_valid), .out_ready(out_ready)
  );

  skinny_round_ctrl #(.NUM_ROUNDS(NR_B), .ROUND_CYCLES(RC_B), .RW(RW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(b_in_ready),
    .load(b_load), .round_en(b_round_en), .roundcst(b_roundcst), .round_idx(b_round_idx),
    .first_round(b_first), .last_round(b_last), .out_valid(b_out_valid), .out_ready(out_ready)
  );

  int errors = 0;
  int checks = 0;

  logic [5:0] rc_tab [0:63];
  logic [5:0] t1_cst [0:5] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};
  logic [5:0] t2_cst [0:3] = '{6'h01, 6'h03, 6'h07, 6'h0F};

  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t    m_phase [2] = '{M_IDLE, M_IDLE};
  int         m_t     [2] = '{0, 0};
  logic [5:0] m_cst   [2] = '{6'h00, 6'h00};
  int         m_idx   [2] = '{0, 0};

  function automatic int nr_of(input int k);
    return (k == 0) ? NR_A : NR_B;
  endfunction

  function automatic int rc_of(input int k);
    return (k == 0) ? RC_A : RC_B;
  endfunction

  task automatic check_output(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%s]: got %0h, expected %0h at %0t", name, (k == 0) ? "A" : "B",
               act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic ordy, input logic ab);
    in_valid  = iv;
    out_ready = ordy;
    abort     = ab;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Model: a block is just a count of cycles since accept; round = t / ROUND_CYCLES
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || abort) begin
        m_phase[k] <= M_IDLE;
        m_t[k]     <= 0;
        m_cst[k]   <= 6'h00;
        m_idx[k]   <= 0;
      end else begin
        case (m_phase[k])
          M_IDLE: if (in_valid) begin
            m_phase[k] <= M_RUN;
            m_t[k]     <= 0;
          end
          M_RUN: if (m_t[k] == nr_of(k) * rc_of(k) - 1) begin
            m_phase[k] <= M_DONE;
            m_cst[k]   <= rc_tab[nr_of(k) - 1];
            m_idx[k]   <= nr_of(k) - 1;
          end else begin
            m_t[k] <= m_t[k] + 1;
          end
          M_DONE: if (out_ready) m_phase[k] <= M_IDLE;
          default: m_phase[k] <= M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int nr, rcy, r;
      logic e_ready, e_load, e_en, e_first, e_last, e_ov;
      logic [5:0] e_cst;
      int e_idx;
      logic a_rdy, a_ld, a_en, a_fst, a_lst, a_ov;
      logic [5:0] a_cst;
      logic [7:0] a_idx;
      nr  = nr_of(k);
      rcy = rc_of(k);
      e_ready = (m_phase[k] == M_IDLE);
      e_load  = e_ready && in_valid && !abort;
      e_ov    = (m_phase[k] == M_DONE);
      if (m_phase[k] == M_RUN) begin
        r       = m_t[k] / rcy;
        e_cst   = rc_tab[r];
        e_idx   = r;
        e_en    = ((m_t[k] % rcy) == rcy - 1);
        e_first = (r == 0);
        e_last  = (r == nr - 1);
      end else begin
        e_cst   = m_cst[k];
        e_idx   = m_idx[k];
        e_en    = 1'b0;
        e_first = 1'b0;
        e_last  = 1'b0;
      end
      if (k == 0) begin
        {a_rdy, a_ld, a_en, a_fst, a_lst, a_ov} =
          {a_in_ready, a_load, a_round_en, a_first, a_last, a_out_valid};
        a_cst = a_roundcst;
        a_idx = 8'(a_round_idx);
      end else begin
        {a_rdy, a_ld, a_en, a_fst, a_lst, a_ov} =
          {b_in_ready, b_load, b_round_en, b_first, b_last, b_out_valid};
        a_cst = b_roundcst;
        a_idx = 8'(b_round_idx);
      end
      check_output("in_ready", k, 32'(a_rdy), 32'(e_ready));
      check_output("load", k, 32'(a_ld), 32'(e_load));
      check_output("round_en", k, 32'(a_en), 32'(e_en));
      check_output("roundcst", k, 32'(a_cst), 32'(e_cst));
      check_output("round_idx", k, 32'(a_idx), 32'(e_idx));
      check_output("first_round", k, 32'(a_fst), 32'(e_first));
      check_output("last_round", k, 32'(a_lst), 32'(e_last));
      check_output("out_valid", k, 32'(a_ov), 32'(e_ov));
    end
  end

  initial begin
    int r;
    int last_a, last_b, fa, la, fb, lb;
    r = 1;
    for (int i = 0; i < 64; i++) begin
      rc_tab[i] = 6'(r);
      r = (r * 2) % 64 + ((r / 32 + (r / 16) % 2 + 1) % 2);
    end
    check_output("model_rc5", 0, 32'(rc_tab[5]), 32'h3E);
    check_output("model_rc47", 0, 32'(rc_tab[47]), 32'h04);
    check_output("model_rc55", 0, 32'(rc_tab[55]), 32'h0A);

    $display("[TB] reset");
    apply_stimulus(1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_output("rst_in_ready", 0, 32'(a_in_ready), 32'h1);
    check_output("rst_roundcst", 0, 32'(a_roundcst), 32'h00);
    check_output("rst_round_idx", 0, 32'(a_round_idx), 32'h0);
    check_output("rst_out_valid", 0, 32'(a_out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();

    $display("[TB] nominal block, DONE stall, ignored in_valid");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t1_load", 0, 32'(a_load), 32'h1);
    check_output("t2_load", 1, 32'(b_load), 32'h1);
    next_cycle();
    for (int c = 1; c <= 67; c++) begin
      apply_stimulus(c >= 60 && c < 63, 1'b0, 1'b0);
      @(negedge clk);
      if (c <= 6) check_output("t1_cst", 0, 32'(a_roundcst), 32'(t1_cst[c-1]));
      if (c == 1) check_output("t1_first", 0, 32'(a_first), 32'h1);
      if (c == 48) check_output("t1_cst47", 0, 32'(a_roundcst), 32'h04);
      if (c == 56) begin
        check_output("t1_cst55", 0, 32'(a_roundcst), 32'h0A);
        check_output("t1_last", 0, 32'(a_last), 32'h1);
        check_output("t1_ov_early", 0, 32'(a_out_valid), 32'h0);
      end
      if (c >= 57) begin
        check_output("t3_ov", 0, 32'(a_out_valid), 32'h1);
        check_output("t3_cst", 0, 32'(a_roundcst), 32'h0A);
        check_output("t3_in_ready", 0, 32'(a_in_ready), 32'h0);
        check_output("t3_load", 0, 32'(a_load), 32'h0);
      end
      if (c <= 12) begin
        check_output("t2_cst", 1, 32'(b_roundcst), 32'(t2_cst[(c-1)/3]));
        check_output("t2_round_en", 1, 32'(b_round_en), 32'(c % 3 == 0));
      end
      if (c == 12) check_output("t2_ov_early", 1, 32'(b_out_valid), 32'h0);
      if (c == 13) check_output("t2_ov", 1, 32'(b_out_valid), 32'h1);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("t3_ov_hs", 0, 32'(a_out_valid), 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t3_idle", 0, 32'(a_in_ready), 32'h1);
    check_output("t3_idle", 1, 32'(b_in_ready), 32'h1);
    next_cycle();

    $display("[TB] abort mid-run");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int c = 1; c <= 21; c++) begin
      apply_stimulus(c == 21, 1'b0, c == 21);
      @(negedge clk);
      if (c == 21) begin
        check_output("t4_idx", 0, 32'(a_round_idx), 32'd20);
        check_output("t4_load", 0, 32'(a_load), 32'h0);
      end
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t4_in_ready", 0, 32'(a_in_ready), 32'h1);
    check_output("t4_ov", 0, 32'(a_out_valid), 32'h0);
    check_output("t4_cst", 0, 32'(a_roundcst), 32'h00);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    next_cycle();

    $display("[TB] async reset mid-run");
    for (int c = 1; c <= 31; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (c == 1) check_output("t4_restart", 0, 32'(a_roundcst), 32'h01);
      if (c == 31) check_output("t5_idx", 0, 32'(a_round_idx), 32'd30);
      if (c < 31) next_cycle();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("t5_in_ready", 0, 32'(a_in_ready), 32'h1);
    check_output("t5_cst", 0, 32'(a_roundcst), 32'h00);
    check_output("t5_idx0", 0, 32'(a_round_idx), 32'h0);
    check_output("t5_ov", 1, 32'(b_out_valid), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t5_load", 0, 32'(a_load), 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t5_cst01", 0, 32'(a_roundcst), 32'h01);
    check_output("t5_first", 0, 32'(a_first), 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b1);
    next_cycle();

    $display("[TB] back-to-back blocks");
    last_a = -1; last_b = -1; fa = 0; la = 0; fb = 0; lb = 0;
    for (int c = 0; c < 200; c++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (a_load) begin
        if (last_a >= 0) begin
          check_output("t6_spacing", 0, 32'(c - last_a), 32'(NR_A * RC_A + 2));
          check_output("t6_first_len", 0, 32'(fa), 32'(RC_A));
          check_output("t6_last_len", 0, 32'(la), 32'(RC_A));
        end
        last_a = c; fa = 0; la = 0;
      end
      if (b_load) begin
        if (last_b >= 0) begin
          check_output("t6_spacing", 1, 32'(c - last_b), 32'(NR_B * RC_B + 2));
          check_output("t6_first_len", 1, 32'(fb), 32'(RC_B));
          check_output("t6_last_len", 1, 32'(lb), 32'(RC_B));
        end
        last_b = c; fb = 0; lb = 0;
      end
      fa += int'(a_first); la += int'(a_last);
      fb += int'(b_first); lb += int'(b_last);
      next_cycle();
    end
    check_output("t6_load_seen", 0, 32'(last_a >= 0), 32'h1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
      end
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 149) == 0);
      next_cycle();
    end

    apply_stimulus(1'b0, 1'b0, 1'b0);
    repeat (2) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
